sipo_deframer: RTL
==================

Name: sipo_deframer

Overview:
Serial-to-parallel receiver that sits directly downstream of the PISO shifter. It consumes that block's serial output bit, one bit per enabled clock, and reassembles it into WIDTH-bit words, MSB first. Completed words go to a one-entry output holding register with a valid/ready handshake. Word alignment is set by a sync strobe; partial words and dropped words are flagged.

Parameters:
WIDTH, 4, word width in bits; must be 2 or more.
CONTINUOUS, 0, 0 = return to IDLE after each word; 1 = start the next word immediately without a new sync.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
din  input  1  serial data bit from the PISO serial output.
din_en  input  1  din is sampled only on edges where din_en=1.
sync  input  1  qualified by din_en; marks the current din as the MSB of a new word.
q  output  WIDTH  assembled word.
q_valid  output  1  q holds an unconsumed word.
q_ready  input  1  consumer accepts q on an edge where q_valid=1 and q_ready=1.
overrun  output  1  sticky: a completed word was dropped because the holding register was full.
overrun_clr  input  1  clears overrun; if a new overrun occurs on the same edge, set wins.
frame_err  output  1  one-cycle pulse: sync arrived while a partial word was in progress.
busy  output  1  1 while in SHIFT state.

Behaviour:
- Reset (async, active-high) forces: state=IDLE, shift register=0, bit count=0, q=0, q_valid=0, overrun=0, frame_err=0, busy=0. Reset may assert mid-word; the partial word is discarded and no q_valid is produced.
- Every state update requires din_en=1. When din_en=0, the shift register, count and state all hold. The handshake still operates when din_en=0.
- IDLE state:
  - On din_en=1 and sync=1: capture din as the MSB, set count=1, go to SHIFT.
  - On din_en=1 and sync=0: the bit is ignored.
- SHIFT state, on each din_en=1 edge:
  - Shift left and insert din at the LSB; count increments by 1.
  - When the bit captured is the WIDTH-th bit, the word is complete on that edge.
- Word completion:
  - If q_valid=0, or q_valid=1 with q_ready=1 on the same edge, load q with the completed word and set q_valid=1.
  - Otherwise, drop the word and set overrun=1; q and q_valid are unchanged.
  - Then reset count to 0. With CONTINUOUS=0, go to IDLE. With CONTINUOUS=1, stay in SHIFT and treat the next enabled bit as the MSB.
- Latency: q and q_valid are visible after the same edge that samples the last bit. No extra pipeline stage.
- Sync while count is between 1 and WIDTH-1 (mid-word):
  - Discard the partial word.
  - Capture din as the new MSB, set count=1.
  - Pulse frame_err for exactly one cycle.
- Sync at count=0 in SHIFT (CONTINUOUS=1, word boundary) is a legal realignment; it does not pulse frame_err.
- Handshake:
  - On an edge with q_valid=1 and q_ready=1, q_valid clears unless a new word loads on that same edge. If a new word loads, q_valid stays 1 and q takes the new word.
  - q is stable while q_valid=1 and q_ready=0.
  - q_ready while q_valid=0 has no effect.
- Width rule: the count is CNT_W = clog2(WIDTH+1) bits wide and never exceeds WIDTH.

Decomposition:
- Package sipo_pkg holds:
  - state enum {S_IDLE, S_SHIFT};
  - function or constant for CNT_W;
  - default WIDTH constant shared with the PISO.
- One sub-module: sipo_out_reg. It is the WIDTH-bit holding register with q_valid/q_ready and the overrun-detect output. The top module holds the FSM, the shift register and the count.

Test Plan:
1. WIDTH=4. After reset, din_en=1 every cycle. Drive sync with din=0, then din=1,0,0. Result: q=4'b0100 and q_valid=1 after the 4th edge; with q_ready=1 one cycle later, q_valid=0.
2. Hold q_ready=0 and send 4'b0100 then 4'b1110. Result: q stays 4'b0100, overrun=1 after the 8th bit edge. Pulse overrun_clr: overrun=0.
3. Send sync with 1,1, then sync again with 1,0,1,1. Result: frame_err pulses for one cycle on the second sync; final q=4'b1011 with no q_valid for the partial "11".
4. CONTINUOUS=1, q_ready=1, one sync, then bits 0100 1110 back-to-back. Result: q=0100 then q=1110, q_valid high on two edges exactly 4 cycles apart, no frame_err.
5. Toggle din_en every other cycle while sending 4'b1110. Result: q=4'b1110 after the 4th enabled edge (the 8th clock); din on disabled cycles is ignored.
6. Assert reset after 2 bits of a word, then send a full sync'd 4'b0001. Result: all outputs 0 during reset; q=4'b0001 afterward and no stale bits.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deframer.
// The default word width matches the upstream PISO shifter.
package sipo_pkg;

    localparam int PISO_WIDTH = 4;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    // Bit count runs 0..WIDTH, so it needs room for WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// One-entry output holding register; loads on the completing edge (0 cycles added).
// A word arriving while full and not being drained is dropped and flags sticky overrun.
module sipo_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             word_vld,
    input  logic [WIDTH-1:0] word_dat,
    input  logic             q_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] q_d, q_q;
    logic             q_valid_d, q_valid_q;
    logic             overrun_d, overrun_q;
    logic             accept;

    always_comb begin
        accept    = !q_valid_q || q_ready;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        overrun_d = overrun_q;

        if (word_vld && accept) begin
            q_d       = word_dat;
            q_valid_d = 1'b1;
        end else if (q_valid_q && q_ready) begin
            q_valid_d = 1'b0;
        end

        // A drop on the same edge as a clear must leave the flag set.
        if (word_vld && !accept) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/sipo_deframer.sv
// Reassembles MSB-first serial bits into WIDTH-bit words, aligned by sync.
// Word is visible after the edge sampling its last bit; full holding register drops words.
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int WIDTH      = PISO_WIDTH,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_en,
    input  logic             sync,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state_d, state_q;
    logic [WIDTH-1:0] shreg_d, shreg_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             frame_err_d, frame_err_q;
    logic             word_vld;
    logic [WIDTH-1:0] word_dat;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        frame_err_d = 1'b0;
        word_vld    = 1'b0;
        shifted     = {shreg_q[WIDTH-2:0], din};
        word_dat    = shifted;

        if (din_en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (sync) begin
                        shreg_d = {{(WIDTH-1){1'b0}}, din};
                        cnt_d   = CNT_W'(1);
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (sync) begin
                        // Count 0 here is a word boundary in continuous mode: legal realign.
                        frame_err_d = (cnt_q != '0);
                        shreg_d     = {{(WIDTH-1){1'b0}}, din};
                        cnt_d       = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        word_vld = 1'b1;
                        shreg_d  = '0;
                        cnt_d    = '0;
                        state_d  = CONTINUOUS ? S_SHIFT : S_IDLE;
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    sipo_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk         (clk),
        .reset       (reset),
        .word_vld    (word_vld),
        .word_dat    (word_dat),
        .q_ready     (q_ready),
        .overrun_clr (overrun_clr),
        .q           (q),
        .q_valid     (q_valid),
        .overrun     (overrun)
    );

    assign frame_err = frame_err_q;
    assign busy      = (state_q == S_SHIFT);

endmodule
